sdram_port_arbiter: RTL

Shares the single 32Mx16 SDRAM controller port between three requesters: the SD-card RAM loader (write-only), the audio sample fetcher (read) and the video/sprite fetcher (read). It sits between those clients and the Avalon-style SDRAM controller. It serialises one transaction at a time and returns read data to the issuing requester. The loader has absolute priority; audio and video alternate round-robin.

---
 rtl/sdram_arb_pkg.sv | 11 +
 rtl/sdram_port_arbiter_if.sv | 23 ++
 rtl/sdram_rr_picker.sv | 30 +++
 rtl/sdram_port_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM port arbiter: FSM states, owner IDs and bus widths.
package sdram_arb_pkg;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT} state_t;
   typedef enum logic [1:0] {OWN_LD, OWN_AUD, OWN_VID} owner_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Avalon-style SDRAM controller port; master is the arbiter, slave is the controller.
interface sdram_port_arbiter_if;
   import sdram_arb_pkg::*;

   logic [ADDR_W-1:0] m_address;
   logic              m_write;
   logic              m_read;
   logic [DATA_W-1:0] m_writedata;
   logic              m_waitrequest;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdatavalid;

   modport master (
      output m_address, m_write, m_read, m_writedata,
      input  m_waitrequest, m_readdata, m_readdatavalid
   );

   modport slave (
      input  m_address, m_write, m_read, m_writedata,
      output m_waitrequest, m_readdata, m_readdatavalid
   );

endinterface

// File: rtl/sdram_rr_picker.sv
// Combinational winner select: loader has absolute priority, audio/video alternate on a tie.
module sdram_rr_picker
   import sdram_arb_pkg::*;
(
   input  logic   ld_we,
   input  logic   aud_req,
   input  logic   vid_req,
   input  owner_t last_rd,
   output owner_t win,
   output logic   win_vld
);

   always_comb begin
      win     = OWN_LD;
      win_vld = 1'b1;
      if (ld_we) begin
         win = OWN_LD;
      end else if (aud_req && vid_req) begin
         // On a tie the reader that was not served last goes next.
         win = (last_rd == OWN_AUD) ? OWN_VID : OWN_AUD;
      end else if (aud_req) begin
         win = OWN_AUD;
      end else if (vid_req) begin
         win = OWN_VID;
      end else begin
         win_vld = 1'b0;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises loader writes and audio/video reads onto one SDRAM controller port,
// routing read data back to the requester that issued the read.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                 clk50,
   input  logic                 reset,

   input  logic                 ld_we,
   input  logic [ADDR_W-1:0]    ld_address,
   input  logic [DATA_W-1:0]    ld_data,
   output logic                 ld_op_begun,

   input  logic                 aud_req,
   input  logic [ADDR_W-1:0]    aud_addr,
   output logic                 aud_ack,
   output logic [DATA_W-1:0]    aud_rdata,
   output logic                 aud_rvalid,

   input  logic                 vid_req,
   input  logic [ADDR_W-1:0]    vid_addr,
   output logic                 vid_ack,
   output logic [DATA_W-1:0]    vid_rdata,
   output logic                 vid_rvalid,

   sdram_port_arbiter_if.master ctrl,

   output logic                 busy,
   output logic                 err_timeout
);

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

   state_t            state, state_nxt;
   owner_t            owner, last_rd, win;
   logic              win_vld;
   logic [CNT_W-1:0]  to_cnt;
   logic              rd_done, rd_abort;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   sdram_rr_picker u_picker (
      .ld_we   (ld_we),
      .aud_req (aud_req),
      .vid_req (vid_req),
      .last_rd (last_rd),
      .win     (win),
      .win_vld (win_vld)
   );

   // Returned data takes precedence over a timeout landing in the same cycle.
   assign rd_done  = (state == RD_WAIT) && ctrl.m_readdatavalid;
   assign rd_abort = (state == RD_WAIT) && !ctrl.m_readdatavalid && (to_cnt >= TO_LIM);

   assign ctrl.m_write = (state == WR_CMD);
   assign ctrl.m_read  = (state == RD_CMD);
   assign busy         = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      ld_op_begun = 1'b0;
      aud_ack     = 1'b0;
      vid_ack     = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) state_nxt = (win == OWN_LD) ? WR_CMD : RD_CMD;
         end
         WR_CMD: begin
            if (!ctrl.m_waitrequest) begin
               ld_op_begun = 1'b1;
               state_nxt   = IDLE;
            end
         end
         RD_CMD: begin
            if (!ctrl.m_waitrequest) begin
               aud_ack   = (owner == OWN_AUD);
               vid_ack   = (owner == OWN_VID);
               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rd_done || rd_abort) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         state            <= IDLE;
         owner            <= OWN_LD;
         last_rd          <= OWN_VID;
         to_cnt           <= '0;
         err_timeout      <= 1'b0;
         ctrl.m_address   <= '0;
         ctrl.m_writedata <= '0;
         aud_rdata        <= '0;
         vid_rdata        <= '0;
         aud_rvalid       <= 1'b0;
         vid_rvalid       <= 1'b0;
      end else begin
         state      <= state_nxt;
         aud_rvalid <= 1'b0;
         vid_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  owner <= win;
                  case (win)
                     OWN_LD:  ctrl.m_address <= ld_address;
                     OWN_AUD: ctrl.m_address <= aud_addr;
                     default: ctrl.m_address <= vid_addr;
                  endcase
                  if (win == OWN_LD) ctrl.m_writedata <= ld_data;
               end
            end
            RD_CMD: begin
               if (!ctrl.m_waitrequest) begin
                  last_rd <= owner;
                  to_cnt  <= '0;
               end
            end
            RD_WAIT: begin
               if (rd_done || rd_abort) begin
                  // An aborted read hands back zero so the client never stalls.
                  if (owner == OWN_AUD) begin
                     aud_rdata  <= rd_done ? ctrl.m_readdata : '0;
                     aud_rvalid <= 1'b1;
                  end else begin
                     vid_rdata  <= rd_done ? ctrl.m_readdata : '0;
                     vid_rvalid <= 1'b1;
                  end
                  if (rd_abort) err_timeout <= 1'b1;
               end else begin
                  to_cnt <= sat_inc(to_cnt);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
